traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Receive-side checker for the MR_ctl/SR_ctl light bus driven by the traffic light controller.
//  Sits beside the controller in the PS03 testbench and top level. Samples the light outputs and the
//  MR_cars input the controller sees, then flags illegal light pairs, sequencing and timing violations,
//  and wrong green-extension decisions. Also counts completed secondary-road phases.
// PARAMETERS
//  PARAMETER      45  car threshold; MR_cars >= PARAMETER -> no main-road green extension
//  MR_GREEN_LEN   30  main-road green block length, cycles
//  SR_GREEN_LEN   10  secondary-road green length, cycles
//  YELLOW_LEN      3  yellow length, cycles (both directions)
//  CNT_W          16  width of phase counters
// PORTS
//  clk         in   1      system clock, 1 ns period; all sampling on rising edge
//  rst         in   1      asynchronous, active-low reset
//  MR_ctl      in   2      main-road light (00 dark, 01 red, 10 yellow, 11 green)
//  SR_ctl      in   2      secondary-road light, same encoding
//  MR_cars     in   8      waiting-car count, unsigned; same signal the controller sees
//  err_pulse   out  5      1-cycle flags {decision, timing, seq, illegal, conflict} (bit4..bit0)
//  err_sticky  out  5      OR-accumulated err_pulse; cleared only by reset
//  sr_phases   out  CNT_W  count of completed SR green phases, saturating at all-ones
//  mr_ext      out  CNT_W  count of extended (2-block) MR greens, saturating
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0; phase=DARK; all counters 0.
//  Legal pairs {MR,SR}: 00/00 DARK, 11/01 MG, 10/10 YEL, 01/11 SG. Any other pair is illegal.
//  Flags are registered: a violation sampled at edge N shows in err_pulse during cycle N..N+1.
//  conflict: MR=11 and SR=11 together. This also raises illegal.
//  illegal: pair outside the legal set. Phase -> DARK; checking restarts at the next DARK->MG.
//  Phase FSM (one sample per edge):
//   DARK -> MG on an MG sample. DARK -> YEL or SG raises seq.
//   MG   -> YEL only. YEL(after MG) -> SG only. SG -> YEL only. YEL(after SG) -> MG only.
//   Any other change raises seq. DARK after non-DARK raises seq (controller reset mid-run).
//  Run counter: counts consecutive identical samples; loads 1 on phase change.
//  timing: raised on the sample that ends a run (first sample of the next phase) when:
//   YEL run != YELLOW_LEN; SG run != SR_GREEN_LEN; MG run not a nonzero multiple of MR_GREEN_LEN.
//   Overlength runs flag immediately at sample YELLOW_LEN+1 / SR_GREEN_LEN+1.
//  MG block tracking: blk_cnt 1..MR_GREEN_LEN wraps to 1; ext flag marks the second block.
//   cars_ref <= MR_cars on the edge where blk_cnt becomes MR_GREEN_LEN-1. This matches the controller
//   decision edge, which leads its registered outputs by one cycle.
//  Expected sample after blk_cnt==MR_GREEN_LEN:
//   ext=1 -> YEL. Then mr_ext++.
//   cars_ref==0 -> MG, new first block.
//   0<cars_ref<PARAMETER -> MG, set ext.
//   cars_ref>=PARAMETER -> YEL.
//   Mismatch raises decision (no timing flag for the same event).
//  sr_phases++ on the edge where SG -> YEL is sampled with a correct SG length.
//  Simultaneous violations: all applicable pulse bits set in the same cycle.
//  Counters saturate and never wrap.
// STRUCTURE
//  tl_pkg: light encodings (DARK/RED/YEL/GRN), phase enum (P_DARK, P_MG, P_Y1, P_SG, P_Y2),
//   error bit indices.
//  Sub-module tl_pair_decode: {MR_ctl,SR_ctl} -> phase code + illegal/conflict bits (combinational).
//  Top: phase FSM, run/block counters, cars_ref register, flag and stat registers.
// TESTING
//  Drive with the real controller, MR_cars=50: MG 30, YEL 3, SG 10, YEL 3 repeating; err_sticky=0;
//   sr_phases increments every 46 cycles.
//  Controller with MR_cars=0 for 200 cycles: MG continuous; no flags; sr_phases=0, mr_ext=0.
//  Controller with MR_cars=20: MG 60 cycles per cycle; mr_ext increments; no flags.
//  Forced 11/11 for one cycle inside MG: err_pulse=00011 one cycle later; err_sticky keeps bits.
//  Forced YEL of 4 cycles after MG: timing pulses at the 4th yellow sample; SG of 9 cycles gives a
//   timing pulse at the next YEL.
//  MR_cars=50 but bench holds MG past 30 cycles: decision=1 at sample 31. Then assert rst=0 mid-MG:
//   all outputs 0 immediately (async).

Source files
------------

// File: rtl/tl_pkg.sv
// Shared encodings for the traffic light monitor: light codes, phase enum, error flag layout.
`timescale 1ns/1ps
package tl_pkg;

  localparam logic [1:0] L_DARK = 2'b00;
  localparam logic [1:0] L_RED  = 2'b01;
  localparam logic [1:0] L_YEL  = 2'b10;
  localparam logic [1:0] L_GRN  = 2'b11;

  localparam int unsigned ERR_W = 5;

  typedef enum logic [2:0] {
    P_DARK = 3'd0,
    P_MG   = 3'd1,
    P_Y1   = 3'd2,
    P_SG   = 3'd3,
    P_Y2   = 3'd4
  } phase_e;

  // Bit order {decision, timing, seq, illegal, conflict}, bit4..bit0.
  typedef struct packed {
    logic decision;
    logic timing;
    logic seq;
    logic illegal;
    logic conflict;
  } err_t;

  function automatic logic is_yel(input phase_e p);
    return (p == P_Y1) || (p == P_Y2);
  endfunction

endpackage

// File: rtl/tl_pair_decode.sv
// Maps a {MR,SR} light pair to a phase code; yellow always decodes as P_Y1 and the
// top resolves which yellow it is from context.
`timescale 1ns/1ps
module tl_pair_decode
  import tl_pkg::*;
(
  input  logic [1:0] i_mr,
  input  logic [1:0] i_sr,
  output phase_e     o_phase_c,
  output logic       o_illegal_c,
  output logic       o_conflict_c
);

  always_comb begin
    o_phase_c    = P_DARK;
    o_illegal_c  = 1'b0;
    o_conflict_c = (i_mr == L_GRN) && (i_sr == L_GRN);
    case ({i_mr, i_sr})
      {L_DARK, L_DARK}: o_phase_c = P_DARK;
      {L_GRN,  L_RED }: o_phase_c = P_MG;
      {L_YEL,  L_YEL }: o_phase_c = P_Y1;
      {L_RED,  L_GRN }: o_phase_c = P_SG;
      default:          o_illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the MR/SR light bus: legality, sequencing, run-length timing
// and green-extension decisions, plus completed-phase statistics.
`timescale 1ns/1ps
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int unsigned PARAMETER    = 45,
  parameter int unsigned MR_GREEN_LEN = 30,
  parameter int unsigned SR_GREEN_LEN = 10,
  parameter int unsigned YELLOW_LEN   = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       MR_ctl,
  input  logic [1:0]       SR_ctl,
  input  logic [7:0]       MR_cars,
  output logic [ERR_W-1:0] err_pulse,
  output logic [ERR_W-1:0] err_sticky,
  output logic [CNT_W-1:0] sr_phases,
  output logic [CNT_W-1:0] mr_ext
);

  localparam int unsigned    BLK_W    = $clog2(MR_GREEN_LEN + 1);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(MR_GREEN_LEN);
  localparam logic [BLK_W-1:0] BLK_CAP  = BLK_W'(MR_GREEN_LEN - 1);
  localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] YEL_LEN  = CNT_W'(YELLOW_LEN);
  localparam logic [CNT_W-1:0] YEL_OVER = CNT_W'(YELLOW_LEN + 1);
  localparam logic [CNT_W-1:0] SG_LEN   = CNT_W'(SR_GREEN_LEN);
  localparam logic [CNT_W-1:0] SG_OVER  = CNT_W'(SR_GREEN_LEN + 1);

  phase_e           w_dec_phase;
  logic             w_illegal;
  logic             w_conflict;

  phase_e           r_phase;
  logic [CNT_W-1:0] r_run;
  logic [BLK_W-1:0] r_blk;
  logic             r_ext;
  logic [7:0]       r_cars_ref;

  phase_e           w_phase_nxt;
  logic [CNT_W-1:0] w_run_nxt;
  logic [BLK_W-1:0] w_blk_nxt;
  logic             w_ext_nxt;
  logic             w_cap;
  logic             w_same;
  logic             w_at_dec;
  logic             w_exp_yel;
  logic             w_sr_inc;
  logic             w_ext_inc;
  err_t             w_err;

  tl_pair_decode u_dec (
    .i_mr         (MR_ctl),
    .i_sr         (SR_ctl),
    .o_phase_c    (w_dec_phase),
    .o_illegal_c  (w_illegal),
    .o_conflict_c (w_conflict)
  );

  // Next-state and violation evaluation for the sample taken at this edge.
  always_comb begin
    w_phase_nxt = r_phase;
    w_run_nxt   = r_run;
    w_blk_nxt   = r_blk;
    w_ext_nxt   = r_ext;
    w_cap       = 1'b0;
    w_sr_inc    = 1'b0;
    w_ext_inc   = 1'b0;
    w_err       = '0;
    w_same      = (w_dec_phase == r_phase) || ((w_dec_phase == P_Y1) && (r_phase == P_Y2));
    w_at_dec    = (r_phase == P_MG) && (r_blk == BLK_LAST);
    w_exp_yel   = r_ext || (32'(r_cars_ref) >= PARAMETER);

    if (w_illegal) begin
      w_err.illegal  = 1'b1;
      w_err.conflict = w_conflict;
      w_phase_nxt    = P_DARK;
      w_run_nxt      = RUN_ONE;
    end else begin
      if (w_at_dec) begin
        w_err.decision = w_exp_yel ? (w_dec_phase != P_Y1) : (w_dec_phase != P_MG);
        w_ext_inc      = r_ext && (w_dec_phase == P_Y1);
      end

      if (w_same) begin
        if (r_run != '1) w_run_nxt = r_run + RUN_ONE;
        if (is_yel(r_phase) && (w_run_nxt == YEL_OVER)) w_err.timing = 1'b1;
        if ((r_phase == P_SG) && (w_run_nxt == SG_OVER)) w_err.timing = 1'b1;
        if (r_phase == P_MG) begin
          // Block boundary: continuing green opens a new block, extended only on a mid-range count.
          if (w_at_dec) begin
            w_blk_nxt = BLK_ONE;
            w_ext_nxt = !w_exp_yel && (r_cars_ref != 8'd0);
          end else begin
            w_blk_nxt = r_blk + BLK_ONE;
          end
          w_cap = (w_blk_nxt == BLK_CAP);
        end
      end else begin
        w_run_nxt = RUN_ONE;
        case (r_phase)
          P_DARK: w_err.seq = (w_dec_phase != P_MG);
          P_MG:   w_err.seq = (w_dec_phase != P_Y1);
          P_Y1:   w_err.seq = (w_dec_phase != P_SG);
          P_SG:   w_err.seq = (w_dec_phase != P_Y1);
          P_Y2:   w_err.seq = (w_dec_phase != P_MG);
          default: w_err.seq = 1'b1;
        endcase
        case (r_phase)
          P_Y1, P_Y2: w_err.timing = (r_run != YEL_LEN);
          P_SG:       w_err.timing = (r_run != SG_LEN);
          P_MG:       w_err.timing = (r_blk != BLK_LAST);
          default:    w_err.timing = 1'b0;
        endcase
        w_sr_inc    = (r_phase == P_SG) && (w_dec_phase == P_Y1) && (r_run == SG_LEN);
        w_phase_nxt = ((w_dec_phase == P_Y1) && (r_phase == P_SG)) ? P_Y2 : w_dec_phase;
        if (w_dec_phase == P_MG) begin
          w_blk_nxt = BLK_ONE;
          w_ext_nxt = 1'b0;
          w_cap     = (BLK_ONE == BLK_CAP);
        end
      end
    end
  end

  // Phase state, run/block tracking and the sampled car count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase    <= P_DARK;
      r_run      <= '0;
      r_blk      <= '0;
      r_ext      <= 1'b0;
      r_cars_ref <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_run   <= w_run_nxt;
      r_blk   <= w_blk_nxt;
      r_ext   <= w_ext_nxt;
      if (w_cap) r_cars_ref <= MR_cars;
    end
  end

  // Flag and saturating statistic registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      sr_phases  <= '0;
      mr_ext     <= '0;
    end else begin
      err_pulse  <= w_err;
      err_sticky <= err_sticky | w_err;
      if (w_sr_inc && (sr_phases != '1)) sr_phases <= sr_phases + RUN_ONE;
      if (w_ext_inc && (mr_ext != '1)) mr_ext <= mr_ext + RUN_ONE;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: emulated controller traffic plus forced faults,
// with expected err_pulse values queued per sample and compared one cycle later.
`timescale 1ns/1ps
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  MR_ctl;
  logic [1:0]  SR_ctl;
  logic [7:0]  MR_cars;
  logic [4:0]  err_pulse;
  logic [4:0]  err_sticky;
  logic [15:0] sr_phases;
  logic [15:0] mr_ext;

  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  localparam logic [1:0] DK = 2'b00, RD = 2'b01, YL = 2'b10, GN = 2'b11;

  always #0.5 clk = ~clk;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .MR_ctl     (MR_ctl),
    .SR_ctl     (SR_ctl),
    .MR_cars    (MR_cars),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .sr_phases  (sr_phases),
    .mr_ext     (mr_ext)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample: drive at the falling edge, queue the expected flags, compare after the next rising edge.
  task automatic step(input logic [1:0] mr, input logic [1:0] sr, input logic [7:0] cars,
                      input logic [4:0] exp, input string tag);
    MR_ctl  = mr;
    SR_ctl  = sr;
    MR_cars = cars;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    check(tag, 32'(err_pulse), 32'(exp_q.pop_front()));
  endtask

  task automatic hold(input logic [1:0] mr, input logic [1:0] sr, input logic [7:0] cars,
                      input int n, input string tag);
    for (int i = 0; i < n; i++) step(mr, sr, cars, 5'b00000, tag);
  endtask

  // Well-behaved controller cycle: MG for mg_len, yellow, SR green, yellow.
  task automatic ctl_cycle(input logic [7:0] cars, input int mg_len);
    hold(GN, RD, cars, mg_len, "mg");
    hold(YL, YL, cars, 3, "y1");
    hold(RD, GN, cars, 10, "sg");
    hold(YL, YL, cars, 3, "y2");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulse"},  32'(err_pulse),  32'd0);
    check({tag, "_sticky"}, 32'(err_sticky), 32'd0);
    check({tag, "_srph"},   32'(sr_phases),  32'd0);
    check({tag, "_mrext"},  32'(mr_ext),     32'd0);
  endtask

  initial begin
    rst = 1'b0; MR_ctl = DK; SR_ctl = DK; MR_cars = 8'd0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // Heavy traffic: 30-cycle greens only.
    step(DK, DK, 8'd50, 5'b00000, "dark");
    ctl_cycle(8'd50, 30);
    ctl_cycle(8'd50, 30);
    check("heavy_srph",   32'(sr_phases),  32'd2);
    check("heavy_mrext",  32'(mr_ext),     32'd0);
    check("heavy_sticky", 32'(err_sticky), 32'd0);

    // Moderate traffic: every main green is extended to two blocks.
    ctl_cycle(8'd20, 60);
    ctl_cycle(8'd20, 60);
    check("mod_srph",   32'(sr_phases),  32'd4);
    check("mod_mrext",  32'(mr_ext),     32'd2);
    check("mod_sticky", 32'(err_sticky), 32'd0);

    // No cars: main green runs on indefinitely, then ends at a block boundary once cars appear.
    hold(GN, RD, 8'd0, 200, "mg_idle");
    check("idle_srph",   32'(sr_phases),  32'd4);
    check("idle_mrext",  32'(mr_ext),     32'd2);
    check("idle_sticky", 32'(err_sticky), 32'd0);
    hold(GN, RD, 8'd50, 10, "mg_tail");
    hold(YL, YL, 8'd50, 3, "y1");
    hold(RD, GN, 8'd50, 10, "sg");
    hold(YL, YL, 8'd50, 3, "y2");
    check("tail_srph", 32'(sr_phases), 32'd5);

    // Four-cycle yellow then nine-cycle SR green.
    hold(GN, RD, 8'd50, 30, "mg");
    hold(YL, YL, 8'd50, 3, "y1");
    step(YL, YL, 8'd50, 5'b01000, "yel_over");
    step(RD, GN, 8'd50, 5'b01000, "yel_end");
    hold(RD, GN, 8'd50, 8, "sg_short");
    step(YL, YL, 8'd50, 5'b01000, "sg_end");
    hold(YL, YL, 8'd50, 2, "y2");
    check("timing_sticky", 32'(err_sticky), 32'h08);
    check("timing_srph",   32'(sr_phases),  32'd5);

    // Both greens for one cycle inside MG.
    hold(GN, RD, 8'd50, 10, "mg");
    step(GN, GN, 8'd50, 5'b00011, "conflict");
    hold(GN, RD, 8'd50, 5, "mg_after");
    check("conflict_sticky", 32'(err_sticky), 32'h0B);

    rst = 1'b0;
    #0.2;
    check_zero("rst_a");
    @(negedge clk);
    rst = 1'b1;

    // Green held past the block despite heavy traffic.
    step(DK, DK, 8'd50, 5'b00000, "dark");
    hold(GN, RD, 8'd50, 30, "mg");
    step(GN, RD, 8'd50, 5'b10000, "decision");
    hold(GN, RD, 8'd50, 3, "mg_over");
    check("decision_sticky", 32'(err_sticky), 32'h10);

    // Asynchronous reset between clock edges.
    rst = 1'b0;
    #0.2;
    check_zero("rst_b");
    MR_ctl = DK; SR_ctl = DK;
    @(negedge clk);
    rst = 1'b1;

    // Start-up straight into SR green.
    step(DK, DK, 8'd50, 5'b00000, "dark");
    step(RD, GN, 8'd50, 5'b00100, "seq_dark_sg");
    check("seq_sticky", 32'(err_sticky), 32'h04);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
